// File: rtl/brew_sequencer.sv
// Coffee brew sequencer. Walks ingredients 1..5 for the selected coffee type.
// For each ingredient it reads a dispense time (in units) from an external
// lookup table and holds that ingredient's valve open for
// t_value * TICKS_PER_UNIT cycles.
//
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   start        - brew request, accepted only in IDLE
//   cancel       - abort the current brew, ignored in IDLE
//   c_type       - coffee type (1..4), sampled together with start
//   sel_c_type   - latched coffee type, drives the lookup table
//   ing_type     - current ingredient (0 when idle, 1..5 while brewing)
//   t_value      - dispense time in units, from the lookup table (combinational)
//   valve        - one-hot ingredient valves
//   busy         - high whenever the sequencer is not idle
//   done/aborted/err - one-cycle status pulses
module brew_sequencer #(
    parameter int unsigned TICKS_PER_UNIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cancel,
    input  logic [2:0] c_type,
    output logic [2:0] sel_c_type,
    output logic [2:0] ing_type,
    input  logic [1:0] t_value,
    output logic [4:0] valve,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       err
);

    localparam int unsigned PRESC_W = 16;
    localparam int unsigned UNITS_W = 2;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_UNIT - 1);
    localparam logic [2:0] LAST_ING = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_DISPENSE,
        S_DONE
    } state_t;

    state_t             state, state_nx;
    logic [PRESC_W-1:0] presc, presc_nx;
    logic [UNITS_W-1:0] units, units_nx;
    logic [2:0]         sel_nx, ing_nx;
    logic [4:0]         valve_nx;
    logic               busy_nx, done_nx, aborted_nx, err_nx;

    // State, counters and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            presc      <= '0;
            units      <= '0;
            sel_c_type <= '0;
            ing_type   <= '0;
            valve      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            presc      <= presc_nx;
            units      <= units_nx;
            sel_c_type <= sel_nx;
            ing_type   <= ing_nx;
            valve      <= valve_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            aborted    <= aborted_nx;
            err        <= err_nx;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx   = state;
        presc_nx   = presc;
        units_nx   = units;
        sel_nx     = sel_c_type;
        ing_nx     = ing_type;
        valve_nx   = valve;
        aborted_nx = 1'b0;
        err_nx     = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (c_type >= 3'd1 && c_type <= 3'd4) begin
                        sel_nx   = c_type;
                        ing_nx   = 3'd1;
                        state_nx = S_LOOKUP;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            S_LOOKUP: begin
                if (t_value == 2'd0) begin
                    // Zero time: skip this ingredient without opening a valve
                    if (ing_type == LAST_ING) begin
                        state_nx = S_DONE;
                    end else begin
                        ing_nx = ing_type + 3'd1;
                    end
                end else begin
                    units_nx = t_value;
                    presc_nx = '0;
                    valve_nx = 5'(5'd1 << (ing_type - 3'd1));
                    state_nx = S_DISPENSE;
                end
            end
            S_DISPENSE: begin
                if (presc == PRESC_LAST) begin
                    presc_nx = '0;
                    units_nx = units - UNITS_W'(1);
                    // Last unit just elapsed: close valve and move on
                    if (units == UNITS_W'(1)) begin
                        valve_nx = '0;
                        if (ing_type == LAST_ING) begin
                            state_nx = S_DONE;
                        end else begin
                            ing_nx   = ing_type + 3'd1;
                            state_nx = S_LOOKUP;
                        end
                    end
                end else begin
                    presc_nx = presc + PRESC_W'(1);
                end
            end
            S_DONE: begin
                ing_nx   = '0;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Cancel overrides every other transition while brewing
        if (cancel && state != S_IDLE) begin
            state_nx   = S_IDLE;
            valve_nx   = '0;
            ing_nx     = '0;
            presc_nx   = '0;
            units_nx   = '0;
            aborted_nx = 1'b1;
        end

        done_nx = (state_nx == S_DONE);
        busy_nx = (state_nx != S_IDLE);
    end

endmodule

// File: tb/tb_brew_sequencer.sv
// Directed bench for brew_sequencer with TICKS_PER_UNIT=4 and a small
// behavioural lookup table.
module tb_brew_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       cancel;
    logic [2:0] c_type;
    logic [2:0] sel_c_type;
    logic [2:0] ing_type;
    logic [1:0] t_value;
    logic [4:0] valve;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    brew_sequencer #(.TICKS_PER_UNIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cancel     (cancel),
        .c_type     (c_type),
        .sel_c_type (sel_c_type),
        .ing_type   (ing_type),
        .t_value    (t_value),
        .valve      (valve),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lookup table model: dispense time per (type, ingredient)
    function automatic logic [1:0] lut(input logic [2:0] ct, input logic [2:0] ing);
        logic [1:0] tbl1 [5] = '{2'd2, 2'd3, 2'd0, 2'd0, 2'd1};
        logic [1:0] tbl2 [5] = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
        logic [1:0] tbl3 [5] = '{2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        logic [1:0] tbl4 [5] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd1};
        if (ing < 3'd1 || ing > 3'd5) return 2'd0;
        case (ct)
            3'd1: return tbl1[ing - 3'd1];
            3'd2: return tbl2[ing - 3'd1];
            3'd3: return tbl3[ing - 3'd1];
            3'd4: return tbl4[ing - 3'd1];
            default: return 2'd0;
        endcase
    endfunction

    assign t_value = lut(sel_c_type, ing_type);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Brew trace results
    logic [4:0] run_v   [8];
    int         run_len [8];
    int         nruns;
    int         done_cnt;
    int         done_edge;
    int         abort_cnt;
    int         multi_hot;
    int         last_edge;

    // Follows a brew whose start is already driven. Edge 1 is the start edge.
    // If poke_edge>0, start and a new c_type are applied after that edge.
    task automatic trace_brew(input int max_edges, input int poke_edge);
        logic [4:0] prev;
        prev      = '0;
        nruns     = 0;
        done_cnt  = 0;
        done_edge = -1;
        abort_cnt = 0;
        multi_hot = 0;
        last_edge = 0;
        for (int e = 1; e <= max_edges; e++) begin
            step();
            last_edge = e;
            if (e == 1) start = 1'b0;
            if (poke_edge > 0 && e == poke_edge) begin
                start  = 1'b1;
                c_type = 3'd2;
            end
            if (poke_edge > 0 && e == poke_edge + 1) start = 1'b0;
            if ($countones(valve) > 1) multi_hot++;
            if (valve != '0) begin
                if (valve == prev && nruns > 0) begin
                    run_len[nruns-1]++;
                end else if (nruns < 8) begin
                    run_v[nruns]   = valve;
                    run_len[nruns] = 1;
                    nruns++;
                end
            end
            prev = valve;
            if (done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = e;
            end
            if (aborted) abort_cnt++;
            if (e > 1 && !busy) break;
        end
        chk("brew_terminates", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        cancel = 1'b0;
        c_type = 3'd0;
        step();
        step();

        // Reset state
        chk("rst_sel", 32'(sel_c_type), 32'd0);
        chk("rst_ing", 32'(ing_type), 32'd0);
        chk("rst_valve", 32'(valve), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pulses", {29'd0, done, aborted, err}, 32'd0);
        rst_n = 1'b1;
        step();

        // Cancel in IDLE does nothing
        cancel = 1'b1;
        step();
        chk("idle_cancel_busy", 32'(busy), 32'd0);
        chk("idle_cancel_abort", 32'(aborted), 32'd0);
        cancel = 1'b0;

        // Type 1 brew
        start  = 1'b1;
        c_type = 3'd1;
        trace_brew(60, 0);
        chk("t1_runs", 32'(nruns), 32'd3);
        chk("t1_v0", 32'(run_v[0]), 32'b00001);
        chk("t1_l0", 32'(run_len[0]), 32'd8);
        chk("t1_v1", 32'(run_v[1]), 32'b00010);
        chk("t1_l1", 32'(run_len[1]), 32'd12);
        chk("t1_v2", 32'(run_v[2]), 32'b10000);
        chk("t1_l2", 32'(run_len[2]), 32'd4);
        chk("t1_done_edge", 32'(done_edge), 32'd30);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_onehot", 32'(multi_hot), 32'd0);
        chk("t1_idle_ing", 32'(ing_type), 32'd0);

        // Type 4 brew
        start  = 1'b1;
        c_type = 3'd4;
        trace_brew(60, 0);
        chk("t4_runs", 32'(nruns), 32'd5);
        chk("t4_v0", 32'(run_v[0]), 32'b00001);
        chk("t4_v1", 32'(run_v[1]), 32'b00010);
        chk("t4_v2", 32'(run_v[2]), 32'b00100);
        chk("t4_v3", 32'(run_v[3]), 32'b01000);
        chk("t4_v4", 32'(run_v[4]), 32'b10000);
        chk("t4_lens", {run_len[0][7:0], run_len[1][7:0], run_len[2][7:0], run_len[3][7:0]},
            {8'd4, 8'd4, 8'd4, 8'd8});
        chk("t4_l4", 32'(run_len[4]), 32'd4);
        chk("t4_done_cnt", 32'(done_cnt), 32'd1);
        chk("t4_done_edge", 32'(done_edge), 32'd30);

        // Illegal types: err pulse, stay idle, sel_c_type keeps 4
        start  = 1'b1;
        c_type = 3'd0;
        step();
        start = 1'b0;
        chk("ill0_err", 32'(err), 32'd1);
        chk("ill0_busy", 32'(busy), 32'd0);
        chk("ill0_valve", 32'(valve), 32'd0);
        chk("ill0_sel", 32'(sel_c_type), 32'd4);
        step();
        chk("ill0_err_clr", 32'(err), 32'd0);
        start  = 1'b1;
        c_type = 3'd7;
        step();
        start = 1'b0;
        chk("ill7_err", 32'(err), 32'd1);
        chk("ill7_busy", 32'(busy), 32'd0);
        chk("ill7_sel", 32'(sel_c_type), 32'd4);
        step();
        chk("ill7_err_clr", 32'(err), 32'd0);
        chk("ill7_valve", 32'(valve), 32'd0);

        // Cancel in second cycle of ingredient-2 dispense (valve opens after edge 11)
        start  = 1'b1;
        c_type = 3'd1;
        step();
        start = 1'b0;
        chk("cx_busy_e1", 32'(busy), 32'd1);
        chk("cx_ing_e1", 32'(ing_type), 32'd1);
        chk("cx_sel_e1", 32'(sel_c_type), 32'd1);
        for (int e = 2; e <= 12; e++) step();
        chk("cx_valve_e12", 32'(valve), 32'b00010);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cx_valve", 32'(valve), 32'd0);
        chk("cx_aborted", 32'(aborted), 32'd1);
        chk("cx_ing", 32'(ing_type), 32'd0);
        chk("cx_busy", 32'(busy), 32'd0);
        chk("cx_done", 32'(done), 32'd0);
        step();
        chk("cx_aborted_clr", 32'(aborted), 32'd0);
        chk("cx_no_done", 32'(done), 32'd0);

        // New start accepted after cancel
        start  = 1'b1;
        c_type = 3'd4;
        trace_brew(60, 0);
        chk("cx_restart_done", 32'(done_cnt), 32'd1);
        chk("cx_restart_runs", 32'(nruns), 32'd5);

        // Start and c_type change during DISPENSE are ignored
        start  = 1'b1;
        c_type = 3'd1;
        trace_brew(60, 5);
        chk("mid_runs", 32'(nruns), 32'd3);
        chk("mid_l0", 32'(run_len[0]), 32'd8);
        chk("mid_l1", 32'(run_len[1]), 32'd12);
        chk("mid_l2", 32'(run_len[2]), 32'd4);
        chk("mid_done_edge", 32'(done_edge), 32'd30);
        chk("mid_sel_held", 32'(sel_c_type), 32'd1);

        // Start together with cancel in IDLE starts a brew
        start  = 1'b1;
        cancel = 1'b1;
        c_type = 3'd3;
        step();
        start  = 1'b0;
        cancel = 1'b0;
        chk("sc_busy", 32'(busy), 32'd1);
        chk("sc_aborted", 32'(aborted), 32'd0);
        step();
        step();
        chk("sc_valve", 32'(valve), 32'b00001);

        // Reset during DISPENSE
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mr_valve", 32'(valve), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_ing", 32'(ing_type), 32'd0);
        chk("mr_sel", 32'(sel_c_type), 32'd0);
        chk("mr_pulses", {29'd0, done, aborted, err}, 32'd0);
        step();
        chk("mr_after_pulses", {29'd0, done, aborted, err}, 32'd0);
        chk("mr_after_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/brew_sequencer.md
BREW_SEQUENCER -- requirements
Module: brew_sequencer

Interface
REQ-001 SHALL have parameter: TICKS_PER_UNIT, 4, clock cycles per time unit; legal range 1..65535.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port: start  input  1  request to brew; sampled only in IDLE.
REQ-005 SHALL have port: cancel  input  1  abort the current brew.
REQ-006 SHALL have port: c_type  input  3  coffee type; legal values 1..4; sampled with start.
REQ-007 SHALL have port: sel_c_type  output  3  coffee type driven to the time-lookup table.
REQ-008 SHALL have port: ing_type  output  3  ingredient index driven to the lookup table; 0 when idle, 1..5 during a brew.
REQ-009 SHALL have port: t_value  input  2  dispense time, in units, returned combinationally by the lookup table.
REQ-010 SHALL have port: valve  output  5  one-hot ingredient valves; bit (ing-1) open while ingredient ing dispenses.
REQ-011 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port: done  output  1  one-cycle pulse when a brew completes.
REQ-013 SHALL have port: aborted  output  1  one-cycle pulse when a brew is cancelled.
REQ-014 SHALL have port: err  output  1  one-cycle pulse when start arrives with an illegal c_type.

Function
REQ-015 SHALL implement the states IDLE, LOOKUP, DISPENSE and DONE; all outputs SHALL be registered.
REQ-016 In IDLE, start=1 with c_type in 1..4 SHALL latch c_type into sel_c_type, set ing_type=1 and enter LOOKUP on the next edge.
REQ-017 In IDLE, start=1 with c_type 0 or 5..7 SHALL pulse err for one cycle and remain in IDLE; sel_c_type SHALL be unchanged.
REQ-018 LOOKUP SHALL last exactly one cycle and sample t_value for the current ing_type.
REQ-019 In LOOKUP, t_value=0 SHALL skip the ingredient with no valve opened: it goes to LOOKUP with ing_type+1, or to DONE if ing_type=5.
REQ-020 In LOOKUP, t_value>0 SHALL load a units counter with t_value, clear the prescaler, set valve bit (ing_type-1), and enter DISPENSE.
REQ-021 In DISPENSE, the prescaler SHALL count 0..TICKS_PER_UNIT-1 and wrap; each wrap SHALL decrement the units counter.
REQ-022 The valve SHALL stay open for exactly t_value*TICKS_PER_UNIT cycles.
REQ-023 On the wrap that brings the units counter to 0, the block SHALL clear valve and go to LOOKUP with ing_type+1, or to DONE if ing_type=5.
REQ-024 DONE SHALL last one cycle with done=1, then return to IDLE with ing_type=0.
REQ-025 valve SHALL never have more than one bit set, and SHALL be 0 outside DISPENSE.
REQ-026 sel_c_type and t_value captures SHALL be held constant for the whole brew; a change on c_type mid-brew SHALL have no effect.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 cancel=1 in LOOKUP, DISPENSE or DONE SHALL take priority over every other transition: on the next edge the block enters IDLE, clears valve, sets ing_type=0, pulses aborted for one cycle, and suppresses done.
REQ-029 cancel=1 in IDLE SHALL have no effect; start and cancel together in IDLE SHALL start the brew.
REQ-030 The prescaler SHALL be 16 bits wide and the units counter 2 bits wide; neither SHALL wrap outside the sequence defined above.

Reset
REQ-031 While rst_n=0 at a rising edge, the block SHALL enter IDLE with sel_c_type=0, ing_type=0, valve=0, busy=0, done=0, aborted=0, err=0, and the counters cleared.
REQ-032 Reset mid-brew SHALL close all valves on that edge and SHALL NOT pulse aborted or done.

Verification (TICKS_PER_UNIT=4; lookup model: type1 = 2,3,0,0,1; type4 = 1,1,1,2,1)
REQ-033 Test type 1 brew: start with c_type=1 on edge 1 -> valve=00001 for 8 cycles, 00010 for 12 cycles, 10000 for 4 cycles; ingredients 3 and 4 skipped; done high after edge 30.
REQ-034 Test type 4 brew: start with c_type=4 -> valve sequence 00001, 00010, 00100, 01000, 10000 with durations 4, 4, 4, 8, 4 cycles; exactly one done pulse.
REQ-035 Test illegal type: start with c_type=0, then with c_type=7 -> one err pulse each; busy stays 0; valve stays 0.
REQ-036 Test cancel: cancel during the second cycle of ingredient-2 dispense -> next cycle valve=0, aborted=1 for one cycle, no done; a new start is then accepted.
REQ-037 Test mid-brew inputs: start and a c_type change applied during DISPENSE -> ignored; brew completes with the originally latched timing.
REQ-038 Test reset: rst_n=0 for one cycle during DISPENSE -> all outputs reach their REQ-031 values on that edge, with no aborted or done pulse.
